// File: rtl/clock_div_controller.sv
// Programmable 50%-duty clock divider with start/stop control.
// A new half-period is held pending and takes effect only at a period
// boundary (the 1->0 edge of clk_out), so no runt or shortened high phase
// is ever produced. Stopping waits for the current high phase to finish.
module clock_div_controller #(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_HALF = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic             running
);

  typedef enum logic [1:0] {STOP, RUN, DRAIN} state_t;

  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] DEF_H  = WIDTH'(DEFAULT_HALF);

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] half_reg;
  logic [WIDTH-1:0] pend_val;
  logic             pend;

  logic toggle;
  logic accept;
  logic apply;

  // A half-period of zero would never terminate a phase; treat it as one.
  function automatic logic [WIDTH-1:0] clamp_half(input logic [WIDTH-1:0] h);
    return (h == '0) ? ONE : h;
  endfunction

  assign toggle    = (state != STOP) && (count == (half_reg - ONE));
  assign cfg_ready = !pend;
  assign accept    = cfg_valid && !pend;
  // Stopped: apply at once. Running: only on the falling edge of clk_out.
  assign apply     = pend && ((state == STOP) || (toggle && clk_out));
  assign running   = (state != STOP);

  // Captured configuration value; only meaningful while pend is set.
  always_ff @(posedge clk) begin
    if (accept) pend_val <= clamp_half(cfg_half);
  end

  // Control FSM, phase counter, divided clock and edge strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STOP;
      count     <= '0;
      half_reg  <= DEF_H;
      pend      <= 1'b0;
      clk_out   <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;

      if (apply) begin
        half_reg <= pend_val;
        pend     <= 1'b0;
      end else if (accept) begin
        pend     <= 1'b1;
      end

      case (state)
        STOP: begin
          count   <= '0;
          clk_out <= 1'b0;
          if (en) state <= RUN;
        end
        default: begin
          if (!en && !clk_out) begin
            // Low phase may be cut short; nothing visible is truncated.
            state <= STOP;
            count <= '0;
          end else if (toggle) begin
            count     <= '0;
            clk_out   <= !clk_out;
            rise_tick <= !clk_out;
            fall_tick <= clk_out;
            state     <= (clk_out && !en) ? STOP : RUN;
          end else begin
            count <= count + ONE;
            state <= en ? RUN : DRAIN;
          end
        end
      endcase
    end
  end

endmodule
